// File: rtl/bd_sequencer.sv
// Shared 8-bit bus sequencer: round-robin arbitration between a W5300 and an SL811 requester,
// producing registered chip-select, address and strobe timing (setup / strobe / hold / done).
module bd_sequencer #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       w_req,
  input  logic       w_rnw,
  input  logic [9:0] w_addr,
  input  logic [7:0] w_wdata,
  output logic       w_ack,
  output logic [7:0] w_rdata,
  input  logic       s_req,
  input  logic       s_rnw,
  input  logic       s_a0,
  input  logic [7:0] s_wdata,
  output logic       s_ack,
  output logic [7:0] s_rdata,
  input  logic [7:0] bd_in,
  output logic [7:0] bd_out,
  output logic       bd_oe,
  output logic       brd_n,
  output logic       bwr_n,
  output logic       w5300_cs_n,
  output logic [9:0] w5300_addr,
  output logic       sl811_cs_n,
  output logic       sl811_a0,
  output logic       busy
);

  localparam int TS = (T_SETUP  < 1) ? 1 : T_SETUP;
  localparam int TB = (T_STROBE < 1) ? 1 : T_STROBE;
  localparam int TH = (T_HOLD   < 1) ? 1 : T_HOLD;
  localparam logic [2:0] TS_LAST = 3'(TS - 1);
  localparam logic [2:0] TB_LAST = 3'(TB - 1);
  localparam logic [2:0] TH_LAST = 3'(TH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       last_s;       // 1 = SL811 was granted last
  logic       sel_w;        // 1 = current transaction belongs to the W5300
  logic       rnw;
  logic [7:0] wdata;

  logic       grant, win_w;
  logic       sel_w_nxt, rnw_nxt, active_nxt;
  logic [7:0] wdata_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    win_w     = 1'b0;
    case (state)
      IDLE: begin
        if (w_req || s_req) begin
          grant     = 1'b1;
          win_w     = w_req && (!s_req || last_s);
          state_nxt = SETUP;
          cnt_nxt   = 3'd0;
        end
      end
      SETUP: begin
        if (cnt == TS_LAST) begin
          state_nxt = STROBE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      STROBE: begin
        if (cnt == TB_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      HOLD: begin
        if (cnt == TH_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from next-state values so they change on the grant edge itself.
    sel_w_nxt  = grant ? win_w : sel_w;
    rnw_nxt    = grant ? (win_w ? w_rnw : s_rnw) : rnw;
    wdata_nxt  = grant ? (win_w ? w_wdata : s_wdata) : wdata;
    active_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_s     <= 1'b1;
      sel_w      <= 1'b0;
      rnw        <= 1'b0;
      wdata      <= 8'h00;
      w5300_cs_n <= 1'b1;
      sl811_cs_n <= 1'b1;
      brd_n      <= 1'b1;
      bwr_n      <= 1'b1;
      bd_oe      <= 1'b0;
      bd_out     <= 8'h00;
      w_ack      <= 1'b0;
      s_ack      <= 1'b0;
      busy       <= 1'b0;
      w5300_addr <= 10'h000;
      sl811_a0   <= 1'b0;
      w_rdata    <= 8'h00;
      s_rdata    <= 8'h00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel_w      <= sel_w_nxt;
      rnw        <= rnw_nxt;
      wdata      <= wdata_nxt;
      if (grant) last_s <= !win_w;
      w5300_cs_n <= !(active_nxt && sel_w_nxt);
      sl811_cs_n <= !(active_nxt && !sel_w_nxt);
      brd_n      <= !((state_nxt == STROBE) && rnw_nxt);
      bwr_n      <= !((state_nxt == STROBE) && !rnw_nxt);
      bd_oe      <= active_nxt && !rnw_nxt;
      bd_out     <= (active_nxt && !rnw_nxt) ? wdata_nxt : 8'h00;
      w_ack      <= (state_nxt == DONE) && sel_w_nxt;
      s_ack      <= (state_nxt == DONE) && !sel_w_nxt;
      busy       <= (state_nxt != IDLE);
      if (grant && win_w)  w5300_addr <= w_addr;
      if (grant && !win_w) sl811_a0   <= s_a0;
      // Capture on the edge that ends the strobe, i.e. the edge brd_n rises.
      if ((state == STROBE) && (state_nxt == HOLD) && rnw) begin
        if (sel_w) w_rdata <= bd_in;
        else       s_rdata <= bd_in;
      end
    end
  end

endmodule

// File: tb/tb_bd_sequencer.sv
// Directed bench for bd_sequencer: default timing instance plus a T_SETUP=0/T_STROBE=7/T_HOLD=1 instance.
module tb_bd_sequencer;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       w_req = 1'b0, w_rnw = 1'b0, s_req = 1'b0, s_rnw = 1'b0, s_a0 = 1'b0;
  logic [9:0] w_addr = '0;
  logic [7:0] w_wdata = '0, s_wdata = '0, bd_in = '0;

  logic       w_ack, s_ack, bd_oe, brd_n, bwr_n, w5300_cs_n, sl811_cs_n, sl811_a0, busy;
  logic [7:0] w_rdata, s_rdata, bd_out;
  logic [9:0] w5300_addr;

  logic       b_w_ack, b_s_ack, b_bd_oe, b_brd_n, b_bwr_n, b_w5300_cs_n, b_sl811_cs_n, b_sl811_a0, b_busy;
  logic [7:0] b_w_rdata, b_s_rdata, b_bd_out;
  logic [9:0] b_w5300_addr;

  int checks = 0;
  int failures = 0;

  always #5 fclk = ~fclk;

  bd_sequencer dut (
    .fclk(fclk), .rst_n(rst_n),
    .w_req(w_req), .w_rnw(w_rnw), .w_addr(w_addr), .w_wdata(w_wdata), .w_ack(w_ack), .w_rdata(w_rdata),
    .s_req(s_req), .s_rnw(s_rnw), .s_a0(s_a0), .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata),
    .bd_in(bd_in), .bd_out(bd_out), .bd_oe(bd_oe), .brd_n(brd_n), .bwr_n(bwr_n),
    .w5300_cs_n(w5300_cs_n), .w5300_addr(w5300_addr), .sl811_cs_n(sl811_cs_n), .sl811_a0(sl811_a0),
    .busy(busy)
  );

  bd_sequencer #(.T_SETUP(0), .T_STROBE(7), .T_HOLD(1)) dut_b (
    .fclk(fclk), .rst_n(rst_n),
    .w_req(w_req), .w_rnw(w_rnw), .w_addr(w_addr), .w_wdata(w_wdata), .w_ack(b_w_ack), .w_rdata(b_w_rdata),
    .s_req(s_req), .s_rnw(s_rnw), .s_a0(s_a0), .s_wdata(s_wdata), .s_ack(b_s_ack), .s_rdata(b_s_rdata),
    .bd_in(bd_in), .bd_out(b_bd_out), .bd_oe(b_bd_oe), .brd_n(b_brd_n), .bwr_n(b_bwr_n),
    .w5300_cs_n(b_w5300_cs_n), .w5300_addr(b_w5300_addr), .sl811_cs_n(b_sl811_cs_n), .sl811_a0(b_sl811_a0),
    .busy(b_busy)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge fclk);
    #1;
  endtask

  task automatic do_reset;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [8:0] obs;
    #1 rst_n = 1'b0;
    #2;
    obs = {brd_n, bwr_n, w5300_cs_n, sl811_cs_n, bd_oe, w_ack, s_ack, busy, sl811_a0};
    checks++;
    if (obs !== 9'b1111_0000_0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", obs, 9'b1111_0000_0);
    end
    checks++;
    if ({bd_out, w_rdata, s_rdata} !== 24'h0 || w5300_addr !== 10'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bd_out, w_rdata, s_rdata, w5300_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || w5300_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle got busy=%b cs=%b exp busy=0 cs=1", busy, w5300_cs_n);
    end
  endtask

  task automatic test_write;
    logic [7:0] obs, exp;
    w_req = 1'b1; w_rnw = 1'b0; w_addr = 10'h2A5; w_wdata = 8'h3C;
    tick();
    w_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      obs = {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack, s_ack, busy};
      exp = {!(c <= 7), 1'b1, 1'b1, !(c >= 2 && c <= 5), (c <= 7), (c == 8), 1'b0, (c <= 8)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL write_ctrl c=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c <= 7) begin
        checks++;
        if (bd_out !== 8'h3C || w5300_addr !== 10'h2A5) begin
          failures++;
          $display("FAIL write_bus c=%0d got=%h/%h exp=3c/2a5", c, bd_out, w5300_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_read;
    logic [7:0] obs, exp;
    s_req = 1'b1; s_rnw = 1'b1; s_a0 = 1'b1;
    tick();
    s_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      bd_in = (c == 5) ? 8'hA7 : 8'h10 + 8'(c);
      obs = {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack, s_ack, busy};
      exp = {1'b1, !(c <= 7), !(c >= 2 && c <= 5), 1'b1, 1'b0, 1'b0, (c == 8), (c <= 8)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL read_ctrl c=%0d got=%b exp=%b", c, obs, exp);
      end
      tick();
    end
    bd_in = 8'hEE;
    tick();
    checks++;
    if (s_rdata !== 8'hA7 || w_rdata !== 8'h00) begin
      failures++;
      $display("FAIL read_data got s=%h w=%h exp s=a7 w=00", s_rdata, w_rdata);
    end
    checks++;
    if (sl811_a0 !== 1'b1 || w5300_addr !== 10'h2A5) begin
      failures++;
      $display("FAIL idle_addr_hold got a0=%b addr=%h exp a0=1 addr=2a5", sl811_a0, w5300_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    logic [7:0] got;
    int acks = 0;
    logic prev_ack = 1'b0;
    exp_q = '{"W", "S", "W", "S"};
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    w_req = 1'b1; s_req = 1'b1; w_rnw = 1'b0; s_rnw = 1'b0;
    w_addr = 10'h011; s_a0 = 1'b0; w_wdata = 8'h21; s_wdata = 8'h42;
    tick();
    checks++;
    if (busy !== 1'b1 || w5300_cs_n !== 1'b0 || sl811_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL first_grant got busy=%b wcs=%b scs=%b exp 1/0/1", busy, w5300_cs_n, sl811_cs_n);
    end
    for (int i = 0; i < 60 && acks < 4; i++) begin
      if (prev_ack) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap got busy=%b exp 0", busy);
        end
      end
      prev_ack = 1'b0;
      if (w_ack === 1'b1 || s_ack === 1'b1) begin
        got = (w_ack === 1'b1 && s_ack === 1'b1) ? "X" : (w_ack === 1'b1 ? "W" : "S");
        checks++;
        if (got !== exp_q[0]) begin
          failures++;
          $display("FAIL arb_order n=%0d got=%c exp=%c", acks, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        acks++;
        prev_ack = 1'b1;
        if (acks == 4) begin
          w_req = 1'b0;
          s_req = 1'b0;
        end
      end
      tick();
    end
    checks++;
    if (acks != 4) begin
      failures++;
      $display("FAIL arb_count got=%0d exp=4", acks);
    end
    w_req = 1'b0; s_req = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    logic [4:0] obs;
    w_req = 1'b1; w_rnw = 1'b0; w_addr = 10'h0AA; w_wdata = 8'h99;
    tick();
    w_req = 1'b0;
    tick();
    tick();
    checks++;
    if (bwr_n !== 1'b0 || w5300_cs_n !== 1'b0 || bd_oe !== 1'b1) begin
      failures++;
      $display("FAIL mid_strobe got bwr=%b cs=%b oe=%b exp 0/0/1", bwr_n, w5300_cs_n, bd_oe);
    end
    #1 rst_n = 1'b0;
    #1;
    obs = {bwr_n, w5300_cs_n, bd_oe, busy, w_ack};
    checks++;
    if (obs !== 5'b11000) begin
      failures++;
      $display("FAIL async_abort got=%b exp=11000", obs);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (w_ack !== 1'b0 || busy !== 1'b0) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL no_ack_after_abort got=%0d exp=0", stray);
    end
    w_req = 1'b1; w_addr = 10'h155; w_wdata = 8'hC3;
    tick();
    w_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (w_ack !== (c == 8) || (c <= 7 && (w5300_addr !== 10'h155 || bd_out !== 8'hC3))) begin
        failures++;
        $display("FAIL post_reset_txn c=%0d got ack=%b addr=%h dout=%h exp ack=%b addr=155 dout=c3",
                 c, w_ack, w5300_addr, bd_out, (c == 8));
      end
      tick();
    end
  endtask

  task automatic test_req_drop;
    w_req = 1'b1; w_rnw = 1'b0; w_addr = 10'h1F0; w_wdata = 8'h5A;
    tick();
    w_req = 1'b0; w_addr = 10'h000; w_wdata = 8'hFF;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (w_ack !== (c == 8) || w5300_cs_n !== !(c <= 7) ||
          (c <= 7 && (w5300_addr !== 10'h1F0 || bd_out !== 8'h5A))) begin
        failures++;
        $display("FAIL req_drop c=%0d got ack=%b cs=%b addr=%h dout=%h exp ack=%b addr=1f0 dout=5a",
                 c, w_ack, w5300_cs_n, w5300_addr, bd_out, (c == 8));
      end
      tick();
    end
  endtask

  task automatic test_params;
    logic [6:0] obs, exp;
    do_reset();
    w_req = 1'b1; w_rnw = 1'b1; w_addr = 10'h300;
    tick();
    w_req = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bd_in = (c == 8) ? 8'h6E : 8'h80 + 8'(c);
      obs = {b_w5300_cs_n, b_sl811_cs_n, b_brd_n, b_bwr_n, b_bd_oe, b_w_ack, b_busy};
      exp = {!(c <= 9), 1'b1, !(c >= 2 && c <= 8), 1'b1, 1'b0, (c == 10), (c <= 10)};
      checks++;
      if (obs !== exp || (b_brd_n | b_bwr_n) !== 1'b1 || (b_w5300_cs_n | b_sl811_cs_n) !== 1'b1) begin
        failures++;
        $display("FAIL param_read c=%0d got=%b exp=%b", c, obs, exp);
      end
      tick();
    end
    checks++;
    if (b_w_rdata !== 8'h6E) begin
      failures++;
      $display("FAIL param_rdata got=%h exp=6e", b_w_rdata);
    end
    s_req = 1'b1; s_rnw = 1'b0; s_a0 = 1'b1; s_wdata = 8'h81;
    tick();
    s_req = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      obs = {b_w5300_cs_n, b_sl811_cs_n, b_brd_n, b_bwr_n, b_bd_oe, b_s_ack, b_busy};
      exp = {1'b1, !(c <= 9), 1'b1, !(c >= 2 && c <= 8), (c <= 9), (c == 10), (c <= 10)};
      checks++;
      if (obs !== exp || (b_brd_n | b_bwr_n) !== 1'b1 || (b_w5300_cs_n | b_sl811_cs_n) !== 1'b1 ||
          (c <= 9 && b_bd_out !== 8'h81)) begin
        failures++;
        $display("FAIL param_write c=%0d got=%b dout=%h exp=%b dout=81", c, obs, b_bd_out, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_req_drop();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
